imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 32, width of the sideband tag (PC) carried with each instruction.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream offers an instruction.
REQ-006 SHALL have port in_ready  output  1  block accepts an instruction this cycle.
REQ-007 SHALL have port in_inst  input  32  raw RV32 instruction word.
REQ-008 SHALL have port in_tag  input  TAG_W  sideband tag.
REQ-009 SHALL have port out_valid  output  1  output entry available.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the output entry.
REQ-011 SHALL have port out_imm  output  XLEN  decoded, sign-extended immediate.
REQ-012 SHALL have port out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the output entry.
REQ-014 SHALL have port out_illegal  output  1  opcode unrecognised or inst[1:0] != 2'b11.

Function
REQ-015 SHALL accept an input when in_valid && in_ready at a rising edge (push).
REQ-016 SHALL pop the head entry when out_valid && out_ready at a rising edge.
REQ-017 SHALL buffer decoded results in a 2-entry in-order FIFO; occupancy count 0..2.
REQ-018 SHALL drive in_ready = (count < 2), from registered state only; no combinational path from out_ready to in_ready.
REQ-019 SHALL drive out_valid = (count > 0); out_imm/out_fmt/out_tag/out_illegal are the head entry, held stable while out_valid && !out_ready.
REQ-020 SHALL have 1-cycle latency: input pushed into an empty buffer at edge N appears with out_valid high after edge N.
REQ-021 SHALL on simultaneous push and pop at count 1 keep count 1 with the new entry at head; at count 0 only push is possible; at count 2 push is blocked.
REQ-022 SHALL decode opcode inst[6:0]: LOAD, LOAD_FP, OP_IMM, JALR -> I; STORE, STORE_FP -> S; BRANCH -> B; LUI, AUIPC -> U; JAL -> J; OP, OP_FP, MISC_MEM, AMO, SYSTEM -> NONE with imm 0, legal.
REQ-023 SHALL form bit fields per standard RV32I I/S/B/U/J layouts; B and J bit 0 is 0; U bits 11:0 are 0.
REQ-024 SHALL sign-extend all I/S/B/U/J immediates from inst[31] to XLEN bits (XLEN=64: U-type bits 63:32 replicate inst[31]).
REQ-025 SHALL for any other opcode, or inst[1:0] != 2'b11, produce imm 0, fmt NONE, illegal 1; the entry still flows through the FIFO in order.
REQ-026 SHALL never drop, duplicate or reorder accepted entries.

Reset
REQ-027 SHALL on reset assertion, asynchronously and regardless of clock: count 0, out_valid 0, in_ready 1 once released, all entry storage and outputs 0.
REQ-028 SHALL discard any buffered entries when reset asserts mid-operation; no push or pop occurs on an edge during reset.

Configuration
REQ-029 SHALL honour macro RVSIMPLE_IMM_ZICSR_EN: when defined, SYSTEM with funct3 in {101,110,111} yields fmt Z, imm = zero-extended inst[19:15]; other SYSTEM encodings remain NONE.
REQ-030 SHALL, without RVSIMPLE_IMM_ZICSR_EN, treat all SYSTEM encodings as fmt NONE, imm 0, illegal 0.

Verification
REQ-031 SHALL test: push 0xFFF00093 (addi -1) into empty block, out_ready=1 -> next cycle out_imm 0xFFFFFFFF, fmt 1; XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
REQ-032 SHALL test: back-to-back 0x123450B7, 0xFE000EE3, 0x0080006F with out_ready=1 -> 0x12345000/U, 0xFFFFFFFC/B, 0x00000008/J on consecutive cycles, tags in order.
REQ-033 SHALL test: out_ready=0, offer 3 instructions -> two accepted, in_ready 0 after second; raise out_ready -> both emerge in order, third accepted next.
REQ-034 SHALL test: 0x3002D073 (csrrwi) -> with macro imm 5, fmt 6; without macro imm 0, fmt 0, illegal 0.
REQ-035 SHALL test: 0x00000013 with inst[1:0] forced to 00 (0x00000010) and opcode 0x7F -> imm 0, fmt 0, illegal 1.
REQ-036 SHALL test: assert reset with count 2 between clock edges -> out_valid drops immediately; after release count 0, in_ready 1, no stale entry emerges.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator feeding a 2-entry in-order output FIFO with 1-cycle latency.
// Optional: define RVSIMPLE_IMM_ZICSR_EN to decode CSR zimm (funct3 101/110/111) as format Z.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_STORE_FP = 7'h27;
  localparam logic [6:0] OPC_AMO      = 7'h2F;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_OP_FP    = 7'h53;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  entry_t          dec;
  entry_t          slot0;
  entry_t          slot1;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  always_comb begin
    imm32       = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (in_inst[6:0])
        OPC_LOAD, OPC_LOAD_FP, OPC_OP_IMM, OPC_JALR: begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        end
        OPC_STORE, OPC_STORE_FP: begin
          dec_fmt = FMT_S;
          imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end
        OPC_BRANCH: begin
          dec_fmt = FMT_B;
          imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          dec_fmt = FMT_U;
          imm32   = {in_inst[31:12], 12'b0};
        end
        OPC_JAL: begin
          dec_fmt = FMT_J;
          imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
        end
        OPC_SYSTEM: begin
`ifdef RVSIMPLE_IMM_ZICSR_EN
          // zimm is zero-extended, so bit 31 stays 0 and the XLEN extension below is harmless
          if (in_inst[14:12] inside {3'b101, 3'b110, 3'b111}) begin
            dec_fmt = FMT_Z;
            imm32   = {27'b0, in_inst[19:15]};
          end
`endif
        end
        OPC_OP, OPC_OP_FP, OPC_MISC_MEM, OPC_AMO: begin
          dec_fmt = FMT_NONE;
        end
        default: begin
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  generate
    if (XLEN == 64) begin : g_ext64
      assign imm_ext = {{32{imm32[31]}}, imm32};
    end else begin : g_ext32
      assign imm_ext = imm32;
    end
  endgenerate

  always_comb begin
    dec         = '0;
    dec.imm     = imm_ext;
    dec.fmt     = dec_fmt;
    dec.tag     = in_tag;
    dec.illegal = dec_illegal;
  end

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // slot0 is always the head; a pop at count 2 shifts slot1 forward
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            slot0 <= dec;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0 <= dec;
          end else if (push) begin
            slot1 <= dec;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            slot0 <= slot1;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  assign out_imm     = slot0.imm;
  assign out_fmt     = slot0.fmt;
  assign out_tag     = slot0.tag;
  assign out_illegal = slot0.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed scenarios plus randomized traffic
// compared against an arithmetic decode model and a queue-based FIFO model.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t exp_q[$];

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [XLEN-1:0] sx(input longint v);
    return v[XLEN-1:0];
  endfunction

  // Decode by arithmetic on the signed word rather than by bit concatenation
  function automatic exp_t model(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
    exp_t e;
    int s;
    int r;
    logic [2:0] f3;
    s = inst;
    r = 0;
    f3 = inst[14:12];
    e.fmt = 3'd0;
    e.ill = 1'b0;
    e.tag = tag;
    if (inst[1:0] != 2'b11) e.ill = 1'b1;
    else begin
      case (inst[6:0])
        7'h03, 7'h07, 7'h13, 7'h67: begin e.fmt = 3'd1; r = s >>> 20; end
        7'h23, 7'h27: begin
          e.fmt = 3'd2;
          r = (s >>> 25) * 32 + int'((inst >> 7) & 32'd31);
        end
        7'h63: begin
          e.fmt = 3'd3;
          r = (s >>> 31) * 4096 + int'((inst >> 7) & 32'd1) * 2048
            + int'((inst >> 25) & 32'd63) * 32 + int'((inst >> 8) & 32'd15) * 2;
        end
        7'h37, 7'h17: begin e.fmt = 3'd4; r = (s >>> 12) * 4096; end
        7'h6F: begin
          e.fmt = 3'd5;
          r = (s >>> 31) * 1048576 + int'((inst >> 12) & 32'd255) * 4096
            + int'((inst >> 20) & 32'd1) * 2048 + int'((inst >> 21) & 32'd1023) * 2;
        end
        7'h73: begin
`ifdef RVSIMPLE_IMM_ZICSR_EN
          if (f3 >= 3'd5) begin e.fmt = 3'd6; r = int'((inst >> 15) & 32'd31); end
`endif
        end
        7'h0F, 7'h2F, 7'h33, 7'h53: r = 0;
        default: e.ill = 1'b1;
      endcase
    end
    e.imm = sx(longint'(r));
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_inst = '0; in_tag = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_imm !== '0 || out_fmt !== 3'd0 || out_tag !== '0 || out_illegal !== 1'b0)
      $display("[TB] FAIL reset_outputs got imm=%h fmt=%0d tag=%h ill=%0b want all 0", out_imm, out_fmt, out_tag, out_illegal);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h1000;
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b1 || out_imm !== sx(-1) || out_fmt !== 3'd1 || out_illegal !== 1'b0 || out_tag !== 32'h1000)
      $display("[TB] FAIL addi got v=%0b imm=%h fmt=%0d ill=%0b tag=%h want v=1 imm=all-ones fmt=1 ill=0 tag=1000",
               out_valid, out_imm, out_fmt, out_illegal, out_tag);
    else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL addi_drain got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts[3];
    logic [XLEN-1:0] imms[3];
    logic [2:0] fmts[3];
    insts = '{32'h123450B7, 32'hFE000EE3, 32'h0080006F};
    imms  = '{sx(64'h12345000), sx(-4), sx(8)};
    fmts  = '{3'd4, 3'd3, 3'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = insts[i]; in_tag = 32'h2000 + 4 * i;
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_imm !== imms[i] || out_fmt !== fmts[i] || out_tag !== 32'h2000 + 4 * i)
        $display("[TB] FAIL b2b_%0d got v=%0b imm=%h fmt=%0d tag=%h want v=1 imm=%h fmt=%0d tag=%h",
                 i, out_valid, out_imm, out_fmt, out_tag, imms[i], fmts[i], 32'h2000 + 4 * i);
      else n_pass++;
    end
    idle();
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL b2b_drain got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500093; in_tag = 32'hA;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready1 got %0b want 1", in_ready); else n_pass++;
    in_inst = 32'h00600113; in_tag = 32'hB;
    tick();
    n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready2 got %0b want 0", in_ready); else n_pass++;
    in_inst = 32'h00700193; in_tag = 32'hC;
    tick();
    n_checks++; if (in_ready !== 1'b0 || out_tag !== 32'hA || out_imm !== sx(5))
      $display("[TB] FAIL bp_hold got rdy=%0b tag=%h imm=%h want rdy=0 tag=a imm=5", in_ready, out_tag, out_imm);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 32'hB || out_imm !== sx(6) || in_ready !== 1'b1)
      $display("[TB] FAIL bp_second got v=%0b tag=%h imm=%h rdy=%0b want v=1 tag=b imm=6 rdy=1", out_valid, out_tag, out_imm, in_ready);
    else n_pass++;
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 32'hC || out_imm !== sx(7))
      $display("[TB] FAIL bp_third got v=%0b tag=%h imm=%h want v=1 tag=c imm=7", out_valid, out_tag, out_imm);
    else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_single(input string name, input logic [31:0] inst,
                             input logic [XLEN-1:0] e_imm, input logic [2:0] e_fmt, input logic e_ill);
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = inst; in_tag = inst;
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b1 || out_imm !== e_imm || out_fmt !== e_fmt || out_illegal !== e_ill)
      $display("[TB] FAIL %s got v=%0b imm=%h fmt=%0d ill=%0b want v=1 imm=%h fmt=%0d ill=%0b",
               name, out_valid, out_imm, out_fmt, out_illegal, e_imm, e_fmt, e_ill);
    else n_pass++;
    tick();
  endtask

  task automatic test_csr_and_illegal();
`ifdef RVSIMPLE_IMM_ZICSR_EN
    test_single("csrrwi", 32'h3002D073, sx(5), 3'd6, 1'b0);
`else
    test_single("csrrwi", 32'h3002D073, sx(0), 3'd0, 1'b0);
`endif
    test_single("csrrw", 32'h30029073, sx(0), 3'd0, 1'b0);
    test_single("low_bits_00", 32'h00000010, sx(0), 3'd0, 1'b1);
    test_single("opcode_7f", 32'hFFFFFFFF, sx(0), 3'd0, 1'b1);
    test_single("sw_neg", 32'hFE112E23, sx(-4), 3'd2, 1'b0);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_tag = 32'h51;
    tick();
    in_inst = 32'h00200093; in_tag = 32'h52;
    tick();
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("[TB] FAIL rst_mid_full got v=%0b rdy=%0b want v=1 rdy=0", out_valid, in_ready);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_tag !== '0 || out_imm !== '0)
      $display("[TB] FAIL rst_mid_async got v=%0b tag=%h imm=%h want all 0", out_valid, out_tag, out_imm);
    else n_pass++;
    tick();
    reset = 1'b0;
    idle(); out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL rst_mid_release got rdy=%0b v=%0b want rdy=1 v=0", in_ready, out_valid);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_mid_stale_%0d got v=%0b want 0", i, out_valid); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs[16];
    logic [31:0] inst;
    logic do_push;
    logic do_pop;
    exp_t h;
    opcs = '{7'h03, 7'h07, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h27, 7'h2F,
             7'h33, 7'h37, 7'h53, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h5B};
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++; if (in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() > 0))
        $display("[TB] FAIL rnd_flags cyc %0d got rdy=%0b v=%0b want occupancy %0d", cyc, in_ready, out_valid, exp_q.size());
      else n_pass++;
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        n_checks++; if (out_imm !== h.imm || out_fmt !== h.fmt || out_tag !== h.tag || out_illegal !== h.ill)
          $display("[TB] FAIL rnd_head cyc %0d got imm=%h fmt=%0d tag=%h ill=%0b want imm=%h fmt=%0d tag=%h ill=%0b",
                   cyc, out_imm, out_fmt, out_tag, out_illegal, h.imm, h.fmt, h.tag, h.ill);
        else n_pass++;
      end
      inst = $urandom();
      if ($urandom_range(0, 7) != 0) inst[6:0] = opcs[$urandom_range(0, 15)];
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_inst   = inst;
      in_tag    = $urandom();
      do_push = in_valid && (exp_q.size() < 2);
      do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(model(in_inst, in_tag));
      tick();
    end
    idle();
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rnd_drain got v=%0b want 0", out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_csr_and_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
